// File: rtl/serial_word_receiver_if.sv
// Link between the serial receiver and its environment: serial bit stream in,
// parallel word out over a valid/ready handshake, plus status pulses.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic             bit_valid;
    logic             dir;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    // Handshake: a word transfers on any active edge where out_valid and
    // out_ready are both 1; out_valid never drops before that transfer.
    modport master (
        output serial_in, bit_valid, dir, out_ready,
        input  parallel_out, out_valid, busy, frame_err, overrun
    );

    modport slave (
        input  serial_in, bit_valid, dir, out_ready,
        output parallel_out, out_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Recovers start/data/stop framed words from a strobed serial stream into a
// holding register; all state advances on the falling edge of clk.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_receiver_if.slave  link,
    output logic [1:0]             state_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && link.out_ready) begin
            valid_d = 1'b0;
        end

        if (link.bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!link.serial_in) begin
                        state_d = DATA;
                        dir_d   = link.dir;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                DATA: begin
                    if (dir_q) begin
                        shift_d = {link.serial_in, shift_q[WIDTH-1:1]};
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], link.serial_in};
                    end
                    // Counter holds on the last bit so it never wraps in-frame.
                    if (cnt_q == LAST) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (link.serial_in) begin
                        if (!valid_q || link.out_ready) begin
                            out_d   = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign link.parallel_out = out_q;
    assign link.out_valid    = valid_q;
    assign link.busy         = (state_q != IDLE);
    assign link.frame_err    = ferr_q;
    assign link.overrun      = ovr_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: framed words in both bit orders,
// framing errors, overruns, strobe gaps and asynchronous reset.
module tb_serial_word_receiver;
    localparam int W = 4;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         checks;
    int         failures;
    logic [W-1:0] exp_q[$];

    serial_word_receiver_if #(.WIDTH(W)) link ();

    serial_word_receiver #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .link    (link),
        .state_o (state_dbg)
    );

    // Clock / reset: active edge is the falling edge at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit; the DUT samples it on the next falling edge, results
    // are observed 1 time unit later.
    task automatic strobe(input logic b, input logic rdy);
        @(posedge clk);
        link.serial_in = b;
        link.bit_valid = 1'b1;
        link.out_ready = rdy;
        @(negedge clk);
        #1;
        link.bit_valid = 1'b0;
        link.out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            link.bit_valid = 1'b0;
            link.serial_in = $urandom_range(0, 1);
            @(negedge clk);
            #1;
        end
    endtask

    // Sends start, WIDTH data bits in the order dir selects, then stop.
    // With gap_max > 0, random idle cycles are inserted and dir is flipped
    // after the start bit.
    task automatic send_frame(input logic d, input logic [W-1:0] word,
                              input logic stop, input logic rdy_stop,
                              input int gap_max);
        link.dir = d;
        strobe(1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (gap_max > 0) begin
                link.dir = ~link.dir;
                idle($urandom_range(0, gap_max));
            end
            strobe(d ? word[i] : word[W-1-i], 1'b0);
        end
        if (gap_max > 0) idle($urandom_range(1, gap_max));
        strobe(stop, rdy_stop);
    endtask

    task automatic consume();
        @(posedge clk);
        link.out_ready = 1'b1;
        @(negedge clk);
        #1;
        link.out_ready = 1'b0;
        check("consume_valid", link.out_valid, 0);
    endtask

    task automatic check_word(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, link.parallel_out, e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pout"}, link.parallel_out, 0);
        check({tag, "_valid"}, link.out_valid, 0);
        check({tag, "_busy"}, link.busy, 0);
        check({tag, "_ferr"}, link.frame_err, 0);
        check({tag, "_ovr"}, link.overrun, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        link.serial_in = 1'b1;
        link.bit_valid = 1'b0;
        link.dir = 1'b0;
        link.out_ready = 1'b0;

        rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        rst = 1'b0;
        idle(2);
        check_idle_outputs("post_reset");

        // MSB first: 0,1,0,1,1,1 -> 1011
        link.dir = 1'b0;
        strobe(1'b0, 1'b0);
        check("msb_busy_start", link.busy, 1);
        check("msb_state_data", state_dbg, 1);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        check("msb_state_stop", state_dbg, 2);
        check("msb_valid_before_stop", link.out_valid, 0);
        strobe(1'b1, 1'b0);
        exp_q.push_back(4'b1011);
        check_word("msb_word");
        check("msb_valid", link.out_valid, 1);
        check("msb_busy_end", link.busy, 0);
        check("msb_ferr", link.frame_err, 0);
        check("msb_ovr", link.overrun, 0);
        idle(3);
        check("msb_valid_held", link.out_valid, 1);
        consume();
        check("msb_word_after_consume", link.parallel_out, 4'b1011);

        // LSB first, same line bits -> 1101
        send_frame(1'b1, 4'b1101, 1'b1, 1'b0, 0);
        exp_q.push_back(4'b1101);
        check_word("lsb_word");
        check("lsb_valid", link.out_valid, 1);
        consume();

        // Framing error from a clean reset state
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("ferr_pre_pout", link.parallel_out, 0);
        send_frame(1'b0, 4'b1100, 1'b0, 1'b0, 0);
        check("ferr_pulse", link.frame_err, 1);
        check("ferr_valid", link.out_valid, 0);
        check("ferr_pout", link.parallel_out, 0);
        check("ferr_busy", link.busy, 0);
        idle(1);
        check("ferr_pulse_end", link.frame_err, 0);

        // Overrun: second word dropped while the first is unconsumed
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0, 0);
        check("ovr_first_valid", link.out_valid, 1);
        send_frame(1'b0, 4'b0110, 1'b1, 1'b0, 0);
        exp_q.push_back(4'b1011);
        check_word("ovr_word_kept");
        check("ovr_pulse", link.overrun, 1);
        check("ovr_valid", link.out_valid, 1);
        idle(1);
        check("ovr_pulse_end", link.overrun, 0);
        consume();

        // Same pair, consumer ready on the second stop edge
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0, 0);
        send_frame(1'b0, 4'b0110, 1'b1, 1'b1, 0);
        exp_q.push_back(4'b0110);
        check_word("rdy_word");
        check("rdy_valid", link.out_valid, 1);
        check("rdy_no_ovr", link.overrun, 0);
        consume();

        // Random gaps and mid-frame dir toggles, both starting orders
        send_frame(1'b0, 4'b1100, 1'b1, 1'b0, 3);
        exp_q.push_back(4'b1100);
        check_word("gap_msb_word");
        check("gap_msb_valid", link.out_valid, 1);
        consume();
        send_frame(1'b1, 4'b0011, 1'b1, 1'b0, 3);
        exp_q.push_back(4'b0011);
        check_word("gap_lsb_word");
        consume();

        // Load a word, then reset mid-frame between clock edges
        send_frame(1'b0, 4'b1001, 1'b1, 1'b0, 0);
        link.dir = 1'b0;
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        check("pre_rst_busy", link.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        @(posedge clk);
        rst = 1'b0;
        idle(1);
        check("post_rst_state", state_dbg, 0);
        send_frame(1'b0, 4'b0101, 1'b1, 1'b0, 0);
        exp_q.push_back(4'b0101);
        check_word("post_rst_word");
        check("post_rst_valid", link.out_valid, 1);
        check("post_rst_ferr", link.frame_err, 0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel receiving end of the shift-register link. The transmitting side loads a word and shifts it out left (MSB first) or right (LSB first). This block recovers framed words from that stream into a parallel holding register. It hands each word to a downstream consumer through a valid/ready handshake and reports framing errors and overruns.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- clk  input  1  clock; all registers update on the falling edge of clk
- rst  input  1  asynchronous, active-high reset
- serial_in  input  1  serial line; sampled only when bit_valid=1
- bit_valid  input  1  bit strobe; one serial bit per falling edge with bit_valid=1
- dir  input  1  bit order: 0 = MSB first (shift left, insert at bit 0); 1 = LSB first (shift right, insert at bit WIDTH-1); sampled on the start-bit edge
- out_ready  input  1  consumer accepts parallel_out on an edge where out_valid=1
- parallel_out  output  WIDTH  last delivered word
- out_valid  output  1  parallel_out holds an unconsumed word
- busy  output  1  frame in progress (state ≠ IDLE)
- frame_err  output  1  one-cycle pulse: stop bit was 0
- overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full

## Operation
- Frame format, counting only strobed bits: start bit 0, then WIDTH data bits, then stop bit 1.
- State IDLE:
  - strobe with serial_in=0 → DATA; latch dir into dir_q; clear bit counter and shift register.
  - strobe with serial_in=1 → stay in IDLE.
- State DATA:
  - Each strobe shifts serial_in into the shift register per dir_q and increments the counter.
  - On the strobe where counter == WIDTH-1, shift that bit in, then go to STOP.
- State STOP, on a strobe:
  - serial_in=1 and holding register free → copy shift register to parallel_out; set out_valid.
  - serial_in=1 and holding register full → pulse overrun; parallel_out is unchanged; the new word is discarded.
  - serial_in=0 → pulse frame_err; the word is discarded; out_valid and parallel_out are unchanged.
  - All three cases return to IDLE.
- The holding register is free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge.
- Handshake:
  - out_valid clears on any edge with out_valid & out_ready, unless a new word loads on that same edge, in which case out_valid stays 1.
  - out_ready while out_valid=0 has no effect.
- Cycles with bit_valid=0 hold all state; gaps of any length are allowed anywhere in a frame.
- dir changes mid-frame are ignored; only dir_q is used.
- A new start bit is detected on the first strobe after returning to IDLE, so back-to-back frames need no idle bits.
- Bit counter width is clog2(WIDTH); it never wraps within a frame.

## Timing
- Reset values, applied immediately on rst, independent of clk: parallel_out=0, out_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counter=0, shift register=0.
- rst asserted mid-frame aborts the frame with no output and no error pulse. Reception resumes on the first start bit after rst deasserts.
- Latency: parallel_out and out_valid update on the falling edge that samples the stop bit. A frame takes WIDTH+2 strobes minimum.
- busy rises on the start-bit edge and falls on the stop-bit edge.
- frame_err and overrun are registered and high for exactly one clk period after the stop-bit edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, dir=0, consecutive strobes 0,1,0,1,1,1 → after the 6th edge parallel_out=4'b1011, out_valid=1, busy=0; no error pulses.
- WIDTH=4, dir=1, same bit sequence → parallel_out=4'b1101, out_valid=1.
- Frame 0,1,1,0,0 with stop bit 0 → frame_err high for one cycle; out_valid stays 0; parallel_out stays 0.
- Two frames (data 1011, then 0110) with out_ready=0 → parallel_out stays 4'b1011; overrun pulses at the second stop edge.
  - Repeat with out_ready=1 on the second stop edge → parallel_out=4'b0110, out_valid=1, no overrun.
- Frame with random bit_valid=0 gaps and dir toggled mid-frame → result identical to the gap-free case using the dir captured at the start bit.
- rst asserted between clock edges during DATA after 2 data bits → all outputs 0 immediately. A following clean frame with data 0101 is received correctly.
